// File: rtl/bnk_be_gen.sv
// Byte-enable and write-data steering for the 8-bank x 32-bit memory model.
// Optional trap-bit range checking is enabled by defining BNK_BE_RANGE_CHECK_EN.
module bnk_be_gen #(
  parameter int ENTRY_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        a,
  input  logic [3:0]         be,
  input  logic               write,
  input  logic               read,
  input  logic               bypass,
  input  logic [255:0]       wd,
  output logic [31:0]        bnk_be,
  output logic [255:0]       bnk_wd,
  output logic [7:0]         bnk_sel,
  output logic [ENTRY_W-1:0] entry,
  output logic               valid,
  output logic               range_err
);

  logic [2:0]   bank;
  logic [7:0]   sel_next;
  logic [3:0]   mode_be;
  logic [31:0]  be_next;
  logic [255:0] wd_next;
  logic         err_next;
  logic         unused_addr_bits;

  assign bank = a[4:2];

  always_comb begin
    sel_next = 8'd1 << bank;
    mode_be  = bypass ? (be & {4{write}}) : {4{write}};
    be_next  = '0;
    wd_next  = '0;
    err_next = 1'b0;
    for (int k = 0; k < 8; k++) begin
      // Line mode enables every bank; bypass only the decoded one.
      be_next[4*k +: 4]  = mode_be & {4{bypass ? sel_next[k] : 1'b1}};
      wd_next[32*k +: 32] = bypass ? wd[31:0] : wd[32*k +: 32];
    end
`ifdef BNK_BE_RANGE_CHECK_EN
    err_next = (|a[31:ENTRY_W+5]) & (read | write);
    if ((|a[31:ENTRY_W+5]) && write)
      be_next = '0;
`endif
  end

  // Without range checking the trap bits simply wrap the address.
  assign unused_addr_bits = ^{a[1:0], a[31:ENTRY_W+5]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bnk_be    <= '0;
      bnk_wd    <= '0;
      bnk_sel   <= '0;
      entry     <= '0;
      valid     <= 1'b0;
      range_err <= 1'b0;
    end else begin
      bnk_be    <= be_next;
      bnk_wd    <= wd_next;
      bnk_sel   <= sel_next;
      entry     <= a[ENTRY_W+4:5];
      valid     <= read;
      range_err <= err_next;
    end
  end

endmodule

// File: tb/tb_bnk_be_gen.sv
// Scoreboard bench for bnk_be_gen: directed vectors push expectations,
// a negedge monitor pops and compares the registered outputs.
module tb_bnk_be_gen;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  a;
  logic [3:0]   be;
  logic         write, read, bypass;
  logic [255:0] wd;
  logic [31:0]  bnk_be;
  logic [255:0] bnk_wd;
  logic [7:0]   bnk_sel;
  logic [9:0]   entry;
  logic         valid, range_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic [31:0]  be;
    logic [255:0] wd;
    logic [7:0]   sel;
    logic [9:0]   entry;
    logic         valid;
    logic         err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  bnk_be_gen #(.ENTRY_W(10)) dut (
    .clk(clk), .reset(reset), .a(a), .be(be), .write(write), .read(read),
    .bypass(bypass), .wd(wd), .bnk_be(bnk_be), .bnk_wd(bnk_wd),
    .bnk_sel(bnk_sel), .entry(entry), .valid(valid), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".bnk_be"}, 256'(bnk_be), '0);
    checkOutput({tag, ".bnk_wd"}, bnk_wd, '0);
    checkOutput({tag, ".bnk_sel"}, 256'(bnk_sel), '0);
    checkOutput({tag, ".entry"}, 256'(entry), '0);
    checkOutput({tag, ".valid"}, 256'(valid), '0);
    checkOutput({tag, ".range_err"}, 256'(range_err), '0);
  endtask

  // Drive one cycle of inputs and queue the response expected after the edge.
  task automatic applyStimulus(input string name, input logic [31:0] ia,
                               input logic [3:0] ibe, input logic iw,
                               input logic ir, input logic ibyp,
                               input logic [255:0] iwd,
                               input logic [31:0] ebe, input logic [255:0] ewd,
                               input logic [7:0] esel, input logic [9:0] eent,
                               input logic evalid, input logic eerr);
    exp_t e;
    a = ia; be = ibe; write = iw; read = ir; bypass = ibyp; wd = iwd;
    e.name = name; e.be = ebe; e.wd = ewd; e.sel = esel;
    e.entry = eent; e.valid = evalid; e.err = eerr;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checkOutput({mon_e.name, ".bnk_be"}, 256'(bnk_be), 256'(mon_e.be));
      checkOutput({mon_e.name, ".bnk_wd"}, bnk_wd, mon_e.wd);
      checkOutput({mon_e.name, ".bnk_sel"}, 256'(bnk_sel), 256'(mon_e.sel));
      checkOutput({mon_e.name, ".entry"}, 256'(entry), 256'(mon_e.entry));
      checkOutput({mon_e.name, ".valid"}, 256'(valid), 256'(mon_e.valid));
      checkOutput({mon_e.name, ".range_err"}, 256'(range_err), 256'(mon_e.err));
    end
  end

  logic [255:0] line_wd;
  logic [31:0]  w;
  int           drain;

  initial begin
    reset = 1'b0; a = '0; be = '0; write = 1'b0; read = 1'b0; bypass = 1'b0; wd = '0;
    line_wd = {32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
               32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset_init");
    reset = 1'b1;

    applyStimulus("byp_byte_wr", 32'h0000_0014, 4'b0010, 1, 0, 1,
                  {224'h0, 32'hDEADBEEF},
                  32'h0020_0000, {8{32'hDEADBEEF}}, 8'h20, 10'd0, 0, 0);
    applyStimulus("line_wr", 32'h0000_0040, 4'h0, 1, 0, 0, line_wd,
                  32'hFFFF_FFFF, line_wd, 8'h01, 10'd2, 0, 0);
    applyStimulus("read_only", 32'h0000_7FE0, 4'h0, 0, 1, 1, '0,
                  32'h0, '0, 8'h01, 10'h3FF, 1, 0);
    applyStimulus("read_drop", 32'h0000_0000, 4'h0, 0, 0, 1, '0,
                  32'h0, '0, 8'h01, 10'd0, 0, 0);
    applyStimulus("byp_no_write", 32'h0000_000C, 4'hF, 0, 0, 1,
                  {224'h0, 32'hCAFEF00D},
                  32'h0, {8{32'hCAFEF00D}}, 8'h08, 10'd0, 0, 0);
    applyStimulus("byp_be_zero", 32'h0000_0010, 4'h0, 1, 0, 1,
                  {224'h0, 32'h1234_5678},
                  32'h0, {8{32'h1234_5678}}, 8'h10, 10'd0, 0, 0);
    applyStimulus("rd_wr_same", 32'h0000_0028, 4'h9, 1, 1, 1,
                  {224'h0, 32'hA5A5_5A5A},
                  32'h0000_0900, {8{32'hA5A5_5A5A}}, 8'h04, 10'd1, 1, 0);
    applyStimulus("line_read", 32'h0000_0064, 4'hF, 0, 1, 0, line_wd,
                  32'h0, line_wd, 8'h02, 10'd3, 1, 0);

    for (int k = 0; k < 8; k++) begin
      w = 32'h1111_1111 * (k + 1);
      applyStimulus($sformatf("sweep%0d", k), 32'(k * 4), 4'hF, 1, 0, 1,
                    {224'h0, w}, 32'hF << (4 * k), {8{w}},
                    8'h01 << k, 10'd0, 0, 0);
    end

`ifdef BNK_BE_RANGE_CHECK_EN
    applyStimulus("range_wr", 32'h0001_0000, 4'hF, 1, 0, 1, {224'h0, 32'h0BAD_0BAD},
                  32'h0, {8{32'h0BAD_0BAD}}, 8'h01, 10'd0, 0, 1);
`else
    applyStimulus("range_wr", 32'h0001_0000, 4'hF, 1, 0, 1, {224'h0, 32'h0BAD_0BAD},
                  32'h0000_000F, {8{32'h0BAD_0BAD}}, 8'h01, 10'd0, 0, 0);
`endif
    applyStimulus("range_idle", 32'h0000_0000, 4'h0, 0, 0, 1, '0,
                  32'h0, '0, 8'h01, 10'd0, 0, 0);

    // Reset asserted between edges must clear outputs with no clock edge.
    a = 32'h0000_0060; be = 4'h0; write = 1'b1; read = 1'b1; bypass = 1'b0; wd = line_wd;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 checkAllZero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset_hold");
    reset = 1'b1;

    applyStimulus("post_reset", 32'h0000_0004, 4'h3, 1, 0, 1, {224'h0, 32'h0F0F_F0F0},
                  32'h0000_0030, {8{32'h0F0F_F0F0}}, 8'h02, 10'd0, 0, 0);

    drain = 0;
    while (sb.size() > 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d pending expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
